if_id_skid_regs: RTL
====================

// Module: if_id_skid_regs
// PURPOSE
//  IF/ID pipeline boundary register with valid/ready handshake, 2-entry skid buffer and flush.
//  Fetch can push a (pc, instruction) pair every cycle; decode can stall without a combinational ready path back into fetch.
//  Flush drops in-flight fetches on a redirect.
//  When nothing is valid, decode sees a NOP bubble. A bubble counter supports perf analysis.
// PARAMETERS
//  INSTR_WIDTH  32            instruction width in bits
//  DATA_WIDTH   64            PC width in bits
//  NOP_INSTR    32'h00000013  encoding driven on instruction_out when out_valid=0 (addi x0,x0,0)
//  CNT_WIDTH    16            bubble counter width
// PORTS
//  clk              in   1            clock; all state updates on posedge
//  reset            in   1            synchronous, active-high reset
//  flush            in   1            discard all held and incoming entries (branch redirect / trap)
//  in_valid         in   1            fetch presents pc_in/instruction_in
//  in_ready         out  1            buffer can accept this cycle
//  pc_in            in   DATA_WIDTH   fetched PC
//  instruction_in   in   INSTR_WIDTH  fetched instruction
//  out_valid        out  1            head entry valid for decode
//  out_ready        in   1            decode consumes head this cycle
//  pc_out           out  DATA_WIDTH   head PC; 0 when out_valid=0
//  instruction_out  out  INSTR_WIDTH  head instruction; NOP_INSTR when out_valid=0
//  bubble_cnt       out  CNT_WIDTH    cycles with out_valid=0 since reset, saturating
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high.
//  - Storage: head slot H (drives outputs) and skid slot S. Occupancy state is EMPTY, ONE (H only) or FULL (H+S).
//  - in_ready = (state != FULL). It is decoded from registered state only; no combinational path from out_ready.
//  - out_valid = (state != EMPTY).
//  - accept = in_valid & in_ready; pop = out_valid & out_ready.
//  - Transitions when flush=0:
//    - EMPTY: accept -> ONE, H<=in.
//    - ONE: accept&pop -> ONE, H<=in. accept&!pop -> FULL, S<=in. pop&!accept -> EMPTY. Otherwise hold.
//    - FULL: accept is impossible. pop -> ONE, H<=S. Otherwise hold.
//  - Latency: an entry accepted at cycle N is visible at the outputs at N+1 when H is free. Sustained throughput is 1/cycle with out_ready=1.
//  - Order is strictly FIFO; no entry is duplicated or dropped except by flush.
//  - flush=1: next state is EMPTY regardless of accept/pop in the same cycle.
//    - Data accepted in the flush cycle is discarded.
//    - A pop in the flush cycle is still a valid consumption by decode; decode owns its own kill.
//    - Flush does not clear payload registers; outputs are masked by out_valid.
//  - reset=1 has priority over flush. Next state is EMPTY; H and S payloads <=0; bubble_cnt<=0.
//  - Reset mid-operation discards all entries.
//  - Values in the cycle after reset: out_valid=0, in_ready=1, pc_out=0, instruction_out=NOP_INSTR, bubble_cnt=0.
//  - bubble_cnt: +1 on every non-reset cycle where out_valid=0 (registered value). Saturates at 2^CNT_WIDTH-1 and does not wrap. Only reset clears it.
//  - While in_valid=1 and in_ready=0, fetch holds pc_in/instruction_in stable. The block does not check this.
// TESTING
//  1. Reset, then in_valid=1 with pc 0x1000,0x1004,0x1008 and out_ready=1 -> outputs show 0x1000,0x1004,0x1008 on consecutive cycles starting 1 cycle after the first accept; in_ready stays 1.
//  2. Fill with 0x2000,0x2004 while out_ready=0 -> in_ready=0 after the 2nd accept. Then out_ready=1 -> 0x2000 then 0x2004, and in_ready=1 in the cycle after the 1st pop.
//  3. FULL, with flush=1 and in_valid=1 (pc 0x3000) in the same cycle -> next cycle out_valid=0, instruction_out=0x00000013, pc_out=0, in_ready=1; 0x3000 never appears.
//  4. ONE with head 0x4000, accept&pop with pc_in=0x4004 -> next cycle head=0x4004, state ONE, no skid use.
//  5. Assert reset while FULL -> next cycle out_valid=0, in_ready=1, bubble_cnt=0; with CNT_WIDTH=4 and 20 idle cycles, bubble_cnt saturates at 15.
//  6. Random in_valid/out_ready (with flush never asserted) over 10k cycles -> scoreboard shows FIFO order, no loss/duplication, and in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/if_id_skid_regs.sv
// IF/ID boundary register with a two-entry skid buffer.
// Head slot H drives decode; skid slot S catches the one extra fetch that
// can arrive while decode stalls, so in_ready comes straight from a register.
module if_id_skid_regs #(
   parameter int                     INSTR_WIDTH = 32,
   parameter int                     DATA_WIDTH  = 64,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h00000013,
   parameter int                     CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  pc_in,
   input  logic [INSTR_WIDTH-1:0] instruction_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  pc_out,
   output logic [INSTR_WIDTH-1:0] instruction_out,
   output logic [CNT_WIDTH-1:0]   bubble_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [DATA_WIDTH-1:0]  r_h_pc;
   logic [INSTR_WIDTH-1:0] r_h_instr;
   logic [DATA_WIDTH-1:0]  r_s_pc;
   logic [INSTR_WIDTH-1:0] r_s_instr;
   logic [CNT_WIDTH-1:0]   r_bubble_cnt;

   logic w_in_ready;
   logic w_out_valid;
   logic w_accept;
   logic w_pop;
   logic w_load_h_in;
   logic w_load_h_s;
   logic w_load_s;

   // Handshake flags decoded from registered occupancy only
   assign w_in_ready  = (r_state != ST_FULL);
   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_accept    = in_valid & w_in_ready;
   assign w_pop       = w_out_valid & out_ready;

   // Occupancy state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_EMPTY;
      else       r_state <= w_state_nxt;
   end

   // Next occupancy and slot load selects; flush overrides everything
   always_comb begin
      w_state_nxt = r_state;
      w_load_h_in = 1'b0;
      w_load_h_s  = 1'b0;
      w_load_s    = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_nxt = ST_ONE;
               w_load_h_in = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_accept && w_pop) begin
               w_load_h_in = 1'b1;
            end else if (w_accept) begin
               w_state_nxt = ST_FULL;
               w_load_s    = 1'b1;
            end else if (w_pop) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_pop) begin
               w_state_nxt = ST_ONE;
               w_load_h_s  = 1'b1;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      if (flush) begin
         w_state_nxt = ST_EMPTY;
         w_load_h_in = 1'b0;
         w_load_h_s  = 1'b0;
         w_load_s    = 1'b0;
      end
   end

   // Payload slots; flush leaves them alone since outputs are masked
   always_ff @(posedge clk) begin
      if (reset) begin
         r_h_pc    <= '0;
         r_h_instr <= '0;
         r_s_pc    <= '0;
         r_s_instr <= '0;
      end else begin
         if (w_load_h_in) begin
            r_h_pc    <= pc_in;
            r_h_instr <= instruction_in;
         end else if (w_load_h_s) begin
            r_h_pc    <= r_s_pc;
            r_h_instr <= r_s_instr;
         end
         if (w_load_s) begin
            r_s_pc    <= pc_in;
            r_s_instr <= instruction_in;
         end
      end
   end

   // Saturating count of cycles in which decode saw a bubble
   always_ff @(posedge clk) begin
      if (reset)
         r_bubble_cnt <= '0;
      else if (!w_out_valid && (r_bubble_cnt != {CNT_WIDTH{1'b1}}))
         r_bubble_cnt <= r_bubble_cnt + 1'b1;
   end

   assign in_ready        = w_in_ready;
   assign out_valid       = w_out_valid;
   assign pc_out          = w_out_valid ? r_h_pc : '0;
   assign instruction_out = w_out_valid ? r_h_instr : NOP_INSTR;
   assign bubble_cnt      = r_bubble_cnt;

endmodule
